// File: rtl/dma_xfer_engine.sv
// DMA transfer engine: moves LEN words (one read then one write per word)
// over a single-outstanding valid/ready bus master using the register-file
// control, io_address and mem_address values.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   cfg_control        [0]=start [1]=dir [2]=abort [16+:LEN_WIDTH]=length
//   cfg_io_address     io-side start address
//   cfg_mem_address    memory-side start address
//   req_valid/write/addr/wdata, req_ready   request channel
//   rsp_valid/rdata/err                      read response channel
//   busy               transfer in progress
//   intr_pulse         one-cycle pulse on completion, abort or error
//   status_err         last transfer ended on a read error (sticky)
//   status_abort       last transfer was aborted (sticky)
//   words_done         words written in the current/last transfer
module dma_xfer_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] cfg_control,
    input  logic [ADDR_WIDTH-1:0] cfg_io_address,
    input  logic [ADDR_WIDTH-1:0] cfg_mem_address,
    output logic                  req_valid,
    output logic                  req_write,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_ready,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  rsp_err,
    output logic                  busy,
    output logic                  intr_pulse,
    output logic                  status_err,
    output logic                  status_abort,
    output logic [LEN_WIDTH-1:0]  words_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_RSP,
        S_WR_REQ,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic                  abort_pend_q, abort_pend_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]  words_done_q, words_done_d;
    logic                  req_valid_q, req_valid_d;
    logic                  req_write_q, req_write_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  busy_q, busy_d;
    logic                  intr_pulse_q, intr_pulse_d;
    logic                  status_err_q, status_err_d;
    logic                  status_abort_q, status_abort_d;

    logic                  start_edge;
    logic                  cfg_dir;
    logic                  cfg_abort;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic                  abort_now;
    logic                  last_word;
    logic                  unused_cfg;

    assign start_edge = cfg_control[0] & ~start_q;
    assign cfg_dir    = cfg_control[1];
    assign cfg_abort  = cfg_control[2];
    assign cfg_len    = cfg_control[16 +: LEN_WIDTH];
    // Only a handful of control bits carry meaning; fold the rest away.
    assign unused_cfg = ^cfg_control;

    // An abort raised in the very cycle a decision is taken still counts.
    assign abort_now  = abort_pend_q | cfg_abort;
    assign last_word  = (words_done_q + LEN_WIDTH'(1)) == len_q;

    always_comb begin
        state_d        = state_q;
        start_d        = cfg_control[0];
        abort_pend_d   = abort_pend_q;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        data_d         = data_q;
        words_done_d   = words_done_q;
        status_err_d   = status_err_q;
        status_abort_d = status_abort_q;

        if (state_q != S_IDLE && cfg_abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    src_d          = cfg_dir ? cfg_mem_address : cfg_io_address;
                    dst_d          = cfg_dir ? cfg_io_address : cfg_mem_address;
                    len_d          = cfg_len;
                    words_done_d   = '0;
                    status_err_d   = 1'b0;
                    status_abort_d = 1'b0;
                    abort_pend_d   = 1'b0;
                    state_d        = (cfg_len != '0) ? S_RD_REQ : S_DONE;
                end
            end
            S_RD_REQ: begin
                if (req_ready) begin
                    state_d = S_RD_RSP;
                end
            end
            S_RD_RSP: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        status_err_d   = 1'b1;
                        status_abort_d = abort_now;
                        state_d        = S_DONE;
                    end else begin
                        data_d  = rsp_rdata;
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (req_ready) begin
                    words_done_d = words_done_q + LEN_WIDTH'(1);
                    src_d        = src_q + STEP;
                    dst_d        = dst_q + STEP;
                    if (last_word || abort_now) begin
                        status_abort_d = abort_now;
                        state_d        = S_DONE;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered images of the next state, so a request
        // appears the cycle after the edge that decided it.
        busy_d       = state_d != S_IDLE;
        intr_pulse_d = state_d == S_DONE;
        req_valid_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        req_write_d  = state_d == S_WR_REQ;
        req_addr_d   = '0;
        req_wdata_d  = '0;
        if (state_d == S_RD_REQ) begin
            req_addr_d = src_d;
        end else if (state_d == S_WR_REQ) begin
            req_addr_d  = dst_d;
            req_wdata_d = data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            abort_pend_q   <= 1'b0;
            src_q          <= '0;
            dst_q          <= '0;
            len_q          <= '0;
            data_q         <= '0;
            words_done_q   <= '0;
            req_valid_q    <= 1'b0;
            req_write_q    <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            busy_q         <= 1'b0;
            intr_pulse_q   <= 1'b0;
            status_err_q   <= 1'b0;
            status_abort_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            abort_pend_q   <= abort_pend_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            len_q          <= len_d;
            data_q         <= data_d;
            words_done_q   <= words_done_d;
            req_valid_q    <= req_valid_d;
            req_write_q    <= req_write_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            busy_q         <= busy_d;
            intr_pulse_q   <= intr_pulse_d;
            status_err_q   <= status_err_d;
            status_abort_q <= status_abort_d;
        end
    end

    assign req_valid    = req_valid_q;
    assign req_write    = req_write_q;
    assign req_addr     = req_addr_q;
    assign req_wdata    = req_wdata_q;
    assign busy         = busy_q;
    assign intr_pulse   = intr_pulse_q;
    assign status_err   = status_err_q;
    assign status_abort = status_abort_q;
    assign words_done   = words_done_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine: linear steps, hand-computed
// expectations, immediate assertions at every comparison.
module tb_dma_xfer_engine;

    logic        clk;
    logic        reset;
    logic [31:0] cfg_control;
    logic [31:0] cfg_io_address;
    logic [31:0] cfg_mem_address;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        intr_pulse;
    logic        status_err;
    logic        status_abort;
    logic [15:0] words_done;

    int n_pass;
    int n_total;

    dma_xfer_engine dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_control    (cfg_control),
        .cfg_io_address (cfg_io_address),
        .cfg_mem_address(cfg_mem_address),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .intr_pulse     (intr_pulse),
        .status_err     (status_err),
        .status_abort   (status_abort),
        .words_done     (words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl(input logic [15:0] len,
                                        input logic dir);
        logic [31:0] v;
        v = {len, 14'd0, dir, 1'b1};
        return v;
    endfunction

    // Expects a read request for a; accepts it, optionally raises abort
    // for one cycle while the response is pending, then returns d/e.
    task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                           input logic e, input bit ab);
        chk("rd_valid", req_valid, 1);
        chk("rd_write", req_write, 0);
        chk("rd_addr", req_addr, a);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("rd_drop", req_valid, 0);
        if (ab) begin
            cfg_control[2] = 1'b1;
            tick();
            cfg_control[2] = 1'b0;
            chk("rsp_wait_busy", busy, 1);
        end
        rsp_valid = 1'b1;
        rsp_rdata = d;
        rsp_err   = e;
        tick();
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
    endtask

    // Expects a write of d to a; holds ready low for stall cycles first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int stall);
        chk("wr_valid", req_valid, 1);
        chk("wr_write", req_write, 1);
        chk("wr_addr", req_addr, a);
        chk("wr_data", req_wdata, d);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("wr_hold_valid", req_valid, 1);
            chk("wr_hold_addr", req_addr, a);
            chk("wr_hold_data", req_wdata, d);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        reset           = 1'b1;
        cfg_control     = '0;
        cfg_io_address  = '0;
        cfg_mem_address = '0;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_err         = 1'b0;

        // Reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_intr", intr_pulse, 0);
        chk("rst_words", words_done, 0);
        chk("rst_err", {status_err, status_abort}, 0);
        reset = 1'b0;
        tick();

        // 1: io->mem, three words, always-ready bus
        cfg_io_address  = 32'h1000;
        cfg_mem_address = 32'h2000;
        cfg_control     = ctl(16'd3, 1'b0);
        tick();
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            do_read(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
            do_write(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), 0);
            chk("t1_words", words_done, 64'(i + 1));
        end
        chk("t1_intr", intr_pulse, 1);
        chk("t1_done_valid", req_valid, 0);
        cfg_control = '0;
        tick();
        chk("t1_intr_end", intr_pulse, 0);
        chk("t1_idle", busy, 0);

        // 2: zero length, no bus traffic
        cfg_control = ctl(16'd0, 1'b0);
        tick();
        chk("t2_valid", req_valid, 0);
        chk("t2_intr", intr_pulse, 1);
        chk("t2_words", words_done, 0);
        cfg_control = '0;
        tick();
        chk("t2_intr_end", intr_pulse, 0);
        chk("t2_idle", busy, 0);

        // 3: second write stalled for five cycles
        cfg_io_address  = 32'h3000;
        cfg_mem_address = 32'h4000;
        cfg_control     = ctl(16'd2, 1'b0);
        tick();
        do_read(32'h3000, 32'h1111_0000, 1'b0, 1'b0);
        do_write(32'h4000, 32'h1111_0000, 0);
        do_read(32'h3004, 32'h2222_0001, 1'b0, 1'b0);
        do_write(32'h4004, 32'h2222_0001, 5);
        chk("t3_intr", intr_pulse, 1);
        chk("t3_words", words_done, 2);
        cfg_control = '0;
        tick();

        // 4: read error on word 2 of 4
        cfg_io_address  = 32'h5000;
        cfg_mem_address = 32'h6000;
        cfg_control     = ctl(16'd4, 1'b0);
        tick();
        do_read(32'h5000, 32'hBEEF, 1'b0, 1'b0);
        do_write(32'h6000, 32'hBEEF, 0);
        do_read(32'h5004, 32'hDEAD, 1'b1, 1'b0);
        chk("t4_no_write", req_valid, 0);
        chk("t4_intr", intr_pulse, 1);
        chk("t4_err", status_err, 1);
        chk("t4_abort", status_abort, 0);
        chk("t4_words", words_done, 1);
        cfg_control = '0;
        tick();
        chk("t4_idle", busy, 0);

        // 5: abort raised while word 1 of 8 awaits its response
        cfg_io_address  = 32'h8000;
        cfg_mem_address = 32'h9000;
        cfg_control     = ctl(16'd8, 1'b0);
        tick();
        chk("t5_err_cleared", status_err, 0);
        do_read(32'h8000, 32'h5A5A, 1'b0, 1'b1);
        do_write(32'h9000, 32'h5A5A, 0);
        chk("t5_intr", intr_pulse, 1);
        chk("t5_abort", status_abort, 1);
        chk("t5_err", status_err, 0);
        chk("t5_words", words_done, 1);
        cfg_control = '0;
        tick();
        chk("t5_idle", busy, 0);

        // 6: mem->io with address wrap, ignored restart, reset mid-write
        cfg_io_address  = 32'h7000;
        cfg_mem_address = 32'hFFFF_FFFC;
        cfg_control     = ctl(16'd2, 1'b1);
        tick();
        cfg_control[0] = 1'b0;
        do_read(32'hFFFF_FFFC, 32'hC0DE, 1'b0, 1'b0);
        cfg_control = ctl(16'd5, 1'b0);
        do_write(32'h7000, 32'hC0DE, 0);
        do_read(32'h0000_0000, 32'hF00D, 1'b0, 1'b0);
        chk("t6_wr_addr", req_addr, 32'h7004);
        chk("t6_wr_valid", req_valid, 1);
        chk("t6_words", words_done, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", req_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_addr", req_addr, 0);
        chk("t6_rst_words", words_done, 0);
        chk("t6_rst_intr", intr_pulse, 0);
        cfg_control = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_post_intr", intr_pulse, 0);
        chk("t6_post_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
